// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin N:1 registered mux.
package rr_mux_pkg;

    localparam int ARB_RR   = 0;
    localparam int ARB_PRIO = 1;

    // Channel index width, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter producing a one-hot grant and its index.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int ARB_MODE = ARB_RR,
    parameter int CH_W     = clog2_min1(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] gnt_idx
);

    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] start;

    always_comb begin : arb_search
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        start   = (ARB_MODE == ARB_PRIO) ? '0 : ptr_q;
        // Scan upward from the start index, wrapping past the top channel.
        for (int off = 0; off < N_CH; off++) begin
            idx = int'(start) + off;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = CH_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (ARB_MODE == ARB_RR && advance) begin
            ptr_d = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rr_mux_nx1.sv
// N:1 channel mux with internal arbitration and a single registered output slot.
module rr_mux_nx1
    import rr_mux_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter int ARB_MODE = ARB_RR,
    parameter int CH_W     = clog2_min1(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CH_W-1:0]  out_ch_q,    out_ch_d;

    logic             slot_free;
    logic             xfer;
    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  gnt;
    logic [CH_W-1:0]  gnt_idx;
    logic [WIDTH-1:0] sel_data;

    assign slot_free = !out_valid_q || out_ready;
    assign req       = in_valid & {N_CH{slot_free}};
    assign in_ready  = rst_n ? gnt : '0;
    assign xfer      = |in_ready;

    rr_arbiter #(
        .N_CH     (N_CH),
        .ARB_MODE (ARB_MODE),
        .CH_W     (CH_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (xfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // A new winner reloads the slot even while it drains, so there is no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
